// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter; a grant stays locked until a byte flagged last (TX_ARB_STATS_EN adds byte/packet counters).
// Latency: req_valid -> req_ready 2 cycles, req_valid -> trans_en 3 cycles when idle and unlocked.
// Backpressure: one byte in flight; a source holds its byte until its req_ready pulse, non-owners wait while a lock is held.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 2,
   parameter int DATA_WIDTH   = 8,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          flush,
   input  logic                          tx_busy,
   output logic [DATA_WIDTH-1:0]         tran_data,
   output logic                          trans_en,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          arb_busy,
   output logic                          timeout
`ifdef TX_ARB_STATS_EN
   ,
   output logic [15:0]                   tx_byte_count,
   output logic [15:0]                   pkt_count
`endif
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_START,
      S_WAIT_RISE,
      S_WAIT_FALL,
      S_RELEASE
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   owner_inc;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   pick_idx;
   logic            pick_vld;
   logic            locked;
   logic            last_f;
   logic            flush_pend;
   logic            idle_flush;
   logic            rel_now;
   logic [CW-1:0]   busy_cnt;
   int              cand;

   logic [DATA_WIDTH-1:0] req_bytes [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign req_bytes[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
   end

   assign owner_inc  = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
   assign grant      = locked ? (NUM_REQ'(1) << owner) : '0;
   assign arb_busy   = (state != S_IDLE);
   assign idle_flush = (state == S_IDLE) && locked && flush;
   // A flush arriving in RELEASE itself is honoured there rather than parked for the next byte.
   assign rel_now    = (state == S_RELEASE) && (last_f || flush_pend || flush);

   // First valid requester at or after rr_ptr; the lowest offset is written last and wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      cand     = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = int'(rr_ptr) + k;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (req_valid[IW'(cand)]) begin
            pick_vld = 1'b1;
            pick_idx = IW'(cand);
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (locked) begin
               if (!flush && req_valid[owner]) begin
                  state_nxt = S_LATCH;
               end
            end else if (pick_vld) begin
               state_nxt = S_LATCH;
            end
         end
         S_LATCH:     state_nxt = S_START;
         S_START:     state_nxt = S_WAIT_RISE;
         S_WAIT_RISE: begin
            if (tx_busy) begin
               state_nxt = S_WAIT_FALL;
            end else if (busy_cnt == CW'(BUSY_TIMEOUT - 1)) begin
               state_nxt = S_RELEASE;
            end
         end
         S_WAIT_FALL: begin
            if (!tx_busy) begin
               state_nxt = S_RELEASE;
            end
         end
         S_RELEASE:   state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         owner      <= '0;
         rr_ptr     <= '0;
         locked     <= 1'b0;
         last_f     <= 1'b0;
         flush_pend <= 1'b0;
         busy_cnt   <= '0;
         tran_data  <= '0;
         req_ready  <= '0;
         trans_en   <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         req_ready <= '0;
         trans_en  <= 1'b0;

         if (idle_flush || rel_now) begin
            locked     <= 1'b0;
            rr_ptr     <= owner_inc;
            flush_pend <= 1'b0;
         end else if (flush && locked && (state != S_IDLE)) begin
            flush_pend <= 1'b1;
         end

         if ((state == S_IDLE) && !locked && pick_vld) begin
            owner  <= pick_idx;
            locked <= 1'b1;
         end

         if (state == S_LATCH) begin
            tran_data <= req_bytes[owner];
            req_ready <= grant;
            last_f    <= req_last[owner];
         end

         if (state == S_START) begin
            trans_en <= 1'b1;
            busy_cnt <= '0;
         end

         // Counting starts in the trans_en cycle, so timeout rises BUSY_TIMEOUT cycles after it.
         if ((state == S_WAIT_RISE) && !tx_busy) begin
            if (busy_cnt == CW'(BUSY_TIMEOUT - 1)) begin
               timeout <= 1'b1;
            end else begin
               busy_cnt <= busy_cnt + CW'(1);
            end
         end
      end
   end

`ifdef TX_ARB_STATS_EN
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tx_byte_count <= '0;
         pkt_count     <= '0;
      end else begin
         if (state == S_START) begin
            tx_byte_count <= tx_byte_count + 16'd1;
         end
         if ((state == S_RELEASE) && last_f) begin
            pkt_count <= pkt_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized packet rounds, checked by a trans_en-driven scoreboard.
module tb_uart_tx_arbiter;

   localparam int NREQ = 2;
   localparam int DW   = 8;
   localparam int BT   = 16;

   typedef struct packed {
      logic [3:0]    idx;
      logic [DW-1:0] dat;
   } exp_t;

   logic              clock     = 1'b0;
   logic              reset_n   = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [NREQ-1:0]   req_last  = '0;
   logic [NREQ*DW-1:0] req_data = '0;
   logic              flush     = 1'b0;
   logic              tx_busy   = 1'b0;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   grant;
   logic [DW-1:0]     tran_data;
   logic              trans_en;
   logic              arb_busy;
   logic              timeout;
`ifdef TX_ARB_STATS_EN
   logic [15:0]       tx_byte_count;
   logic [15:0]       pkt_count;
`endif

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   exp_t        exp_q[$];
   logic [DW:0] src_q[NREQ][$];
   logic [DW:0] new_q[NREQ][$];
   logic [DW:0] mdl_q[NREQ][$];
   int          t_valid[NREQ];
   int          t_ready[NREQ];
   int          n_ready[NREQ];
   int          t_trans   = 0;
   int          n_trans   = 0;
   int          n_trans_rst = 0;
   int          t_tmo     = 0;
   bit          tmo_seen  = 0;
   int          uart_en   = 1;
   int          rand_uart = 0;
   int          rise_dly  = 1;
   int          busy_len  = 4;
   int          u_phase   = 0;
   int          u_left    = 0;
   int          mdl_ptr   = 0;
   int          n_pkts    = 0;
   logic [DW:0] drv_hd;
   exp_t        mon_e;

   uart_tx_arbiter #(.NUM_REQ(NREQ), .DATA_WIDTH(DW), .BUSY_TIMEOUT(BT)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .flush     (flush),
      .tx_busy   (tx_busy),
      .tran_data (tran_data),
      .trans_en  (trans_en),
      .grant     (grant),
      .arb_busy  (arb_busy),
      .timeout   (timeout)
`ifdef TX_ARB_STATS_EN
      ,
      .tx_byte_count (tx_byte_count),
      .pkt_count     (pkt_count)
`endif
   );

   initial forever #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic at_edge();
      @(posedge clock);
      #1;
   endtask

   task automatic load(input int r, input logic [DW:0] b);
      src_q[r].push_back(b);
   endtask

   task automatic expect_b(input int r, input logic [DW-1:0] d);
      exp_t x;
      x.idx = 4'(r);
      x.dat = d;
      exp_q.push_back(x);
   endtask

   task automatic wait_drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || src_q[0].size() != 0 || src_q[1].size() != 0 || arb_busy) && n < 3000) begin
         @(negedge clock);
         n++;
      end
      check({"drain_", name}, 32'(n < 3000), 1);
   endtask

   task automatic wait_ready(input int r, input int target, input string name);
      int n;
      n = 0;
      while (n_ready[r] < target && n < 500) begin
         @(negedge clock);
         n++;
      end
      check(name, 32'(n_ready[r] >= target), 1);
   endtask

   task automatic wait_trans(input int target, input string name);
      int n;
      n = 0;
      while (n_trans < target && n < 500) begin
         @(negedge clock);
         n++;
      end
      check(name, 32'(n_trans >= target), 1);
   endtask

   task automatic wait_grant(input logic [NREQ-1:0] g, input string name);
      int n;
      n = 0;
      while (grant !== g && n < 500) begin
         @(negedge clock);
         n++;
      end
      check(name, grant, g);
   endtask

   task automatic wait_busy_hi(input string name);
      int n;
      n = 0;
      while (!tx_busy && n < 500) begin
         @(negedge clock);
         n++;
      end
      check(name, tx_busy, 1);
   endtask

   // Packet-level reference: whole packets, first non-empty source at or after the pointer.
   task automatic model_rr();
      int r;
      logic [DW:0] it;
      for (int i = 0; i < NREQ; i++) mdl_q[i] = new_q[i];
      while (mdl_q[0].size() + mdl_q[1].size() != 0) begin
         r = -1;
         for (int k = 0; k < NREQ && r < 0; k++) begin
            if (mdl_q[(mdl_ptr + k) % NREQ].size() != 0) r = (mdl_ptr + k) % NREQ;
         end
         do begin
            it = mdl_q[r].pop_front();
            expect_b(r, it[DW-1:0]);
         end while (!it[DW]);
         n_pkts++;
         mdl_ptr = (r + 1) % NREQ;
      end
   endtask

   // UART model: tx_busy rises rise_dly cycles after trans_en and stays high busy_len cycles.
   initial forever begin
      @(negedge clock);
      if (!reset_n) begin
         tx_busy = 1'b0;
         u_phase = 0;
      end else begin
         case (u_phase)
            0: if (trans_en && uart_en != 0) begin
                  if (rand_uart != 0) begin
                     rise_dly = $urandom_range(0, 3);
                     busy_len = $urandom_range(1, 6);
                  end
                  if (rise_dly == 0) begin
                     tx_busy = 1'b1;
                     u_left  = busy_len;
                     u_phase = 2;
                  end else begin
                     u_left  = rise_dly;
                     u_phase = 1;
                  end
               end
            1: begin
                  u_left--;
                  if (u_left == 0) begin
                     tx_busy = 1'b1;
                     u_left  = busy_len;
                     u_phase = 2;
                  end
               end
            2: begin
                  u_left--;
                  if (u_left == 0) begin
                     tx_busy = 1'b0;
                     u_phase = 0;
                  end
               end
            default: u_phase = 0;
         endcase
      end
   end

   // Requester drivers: present the head of each source queue, advance on req_ready.
   initial forever begin
      @(negedge clock);
      for (int i = 0; i < NREQ; i++) begin
         if (reset_n && req_ready[i]) begin
            check("ready_has_data", 32'(src_q[i].size() != 0), 1);
            if (src_q[i].size() != 0) void'(src_q[i].pop_front());
         end
         if (src_q[i].size() != 0) begin
            drv_hd = src_q[i][0];
            if (!req_valid[i]) t_valid[i] = cyc;
            req_valid[i]          = 1'b1;
            req_data[i*DW +: DW]  = drv_hd[DW-1:0];
            req_last[i]           = drv_hd[DW];
         end else begin
            req_valid[i] = 1'b0;
            req_last[i]  = 1'b0;
         end
      end
   end

   // Monitor / scoreboard.
   initial forever begin
      @(negedge clock);
      if (reset_n) begin
         if (req_ready != '0) begin
            check("ready_eq_grant", req_ready, grant);
            for (int i = 0; i < NREQ; i++) begin
               if (req_ready[i]) begin
                  t_ready[i] = cyc;
                  n_ready[i]++;
               end
            end
         end
         if (trans_en) begin
            t_trans = cyc;
            n_trans++;
            check("sb_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("tx_data", tran_data, mon_e.dat);
               check("tx_owner", grant, NREQ'(1) << mon_e.idx);
            end
         end
         if (timeout && !tmo_seen) begin
            tmo_seen = 1'b1;
            t_tmo    = cyc;
         end
      end
   end

   initial begin
      int tgt;
      int np;
      int len;
      for (int i = 0; i < NREQ; i++) begin
         t_valid[i] = 0;
         t_ready[i] = 0;
         n_ready[i] = 0;
      end
      repeat (3) @(negedge clock);
      check("rst_ready", req_ready, 0);
      check("rst_trans_en", trans_en, 0);
      check("rst_grant", grant, 0);
      check("rst_arb_busy", arb_busy, 0);
      check("rst_timeout", timeout, 0);
      check("rst_tran_data", tran_data, 0);
      at_edge();
      reset_n = 1'b1;
      repeat (2) @(negedge clock);

      // Single byte, UART busy for 10 cycles.
      rise_dly = 1;
      busy_len = 10;
      tgt = n_trans + 1;
      at_edge();
      expect_b(0, 8'h80);
      load(0, {1'b1, 8'h80});
      wait_ready(0, 1, "sb_ready_seen");
      check("sb_ready_latency", t_ready[0] - t_valid[0], 2);
      wait_trans(tgt, "sb_trans_seen");
      check("sb_trans_latency", t_trans - t_valid[0], 3);
      wait_busy_hi("sb_busy_seen");
      check("sb_grant_held", grant, 2'b01);
      wait_drain("single");
      check("sb_grant_clear", grant, 0);

      // Packet lock: req1 arrives while req0 owns a 3-byte packet.
      busy_len = 3;
      at_edge();
      load(0, {1'b0, 8'hA1});
      load(0, {1'b0, 8'hA2});
      load(0, {1'b1, 8'hA3});
      expect_b(0, 8'hA1);
      expect_b(0, 8'hA2);
      expect_b(0, 8'hA3);
      expect_b(1, 8'h55);
      wait_grant(2'b01, "lk_grant0");
      at_edge();
      load(1, {1'b1, 8'h55});
      wait_drain("lock");

      // Round robin with both sources continuously valid.
      at_edge();
      for (int k = 0; k < 3; k++) begin
         load(0, {1'b1, 8'(8'h10 + k)});
         load(1, {1'b1, 8'(8'h20 + k)});
      end
      for (int k = 0; k < 3; k++) begin
         expect_b(0, 8'(8'h10 + k));
         expect_b(1, 8'(8'h20 + k));
      end
      wait_drain("rr");

      // Timeout: tx_busy never rises.
      uart_en = 0;
      tgt = n_trans + 1;
      at_edge();
      expect_b(0, 8'h3C);
      load(0, {1'b1, 8'h3C});
      wait_trans(tgt, "to_trans_seen");
      for (int n = 0; n < 100 && !tmo_seen; n++) @(negedge clock);
      check("to_seen", 32'(tmo_seen), 1);
      check("to_delay", t_tmo - t_trans, BT);
      wait_drain("timeout");
      check("to_grant_clear", grant, 0);
      uart_en = 1;
      at_edge();
      expect_b(1, 8'hC3);
      load(1, {1'b1, 8'hC3});
      wait_drain("after_timeout");
      check("to_sticky", timeout, 1);

      // Flush: req1 locked with last never set.
      at_edge();
      load(1, {1'b0, 8'h11});
      load(1, {1'b0, 8'h12});
      load(1, {1'b0, 8'h13});
      expect_b(1, 8'h11);
      expect_b(1, 8'h12);
      expect_b(0, 8'h99);
      expect_b(1, 8'h13);
      wait_grant(2'b10, "fl_grant1");
      at_edge();
      load(0, {1'b1, 8'h99});
      for (int n = 0; n < 500 && src_q[1].size() != 1; n++) @(negedge clock);
      check("fl_two_accepted", src_q[1].size(), 1);
      at_edge();
      flush = 1'b1;
      at_edge();
      flush = 1'b0;
      wait_drain("flush");
      check("fl_lock_after_drain", grant, 2'b10);
      repeat (5) @(negedge clock);
      check("fl_lock_held", grant, 2'b10);
      check("fl_idle", arb_busy, 0);
      at_edge();
      flush = 1'b1;
      at_edge();
      flush = 1'b0;
      @(negedge clock);
      check("fl_idle_release", grant, 0);

      // Reset while the UART is busy with a byte.
      rise_dly = 0;
      busy_len = 20;
      at_edge();
      expect_b(0, 8'h5A);
      load(0, {1'b1, 8'h5A});
      wait_busy_hi("rs_busy_seen");
      repeat (2) @(negedge clock);
      check("rs_mid_byte", arb_busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check("rs_grant", grant, 0);
      check("rs_arb_busy", arb_busy, 0);
      check("rs_tran_data", tran_data, 0);
      check("rs_timeout", timeout, 0);
      check("rs_trans_en", trans_en, 0);
      check("rs_req_ready", req_ready, 0);
`ifdef TX_ARB_STATS_EN
      check("rs_byte_count", tx_byte_count, 0);
      check("rs_pkt_count", pkt_count, 0);
`endif
      repeat (2) @(negedge clock);
      #2 reset_n = 1'b1;
      n_trans_rst = n_trans;
      rise_dly = 1;
      busy_len = 3;
      tgt = n_ready[1] + 1;
      at_edge();
      expect_b(1, 8'h77);
      load(1, {1'b1, 8'h77});
      wait_ready(1, tgt, "rs_ready_seen");
      check("rs_ready_latency", t_ready[1] - t_valid[1], 2);
      wait_drain("after_reset");
      mdl_ptr = 0;
      n_pkts  = 1;

      // Randomized packet rounds against the packet-level model.
      rand_uart = 1;
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < NREQ; i++) begin
            np = $urandom_range(0, 3);
            for (int p = 0; p < np; p++) begin
               len = $urandom_range(1, 4);
               for (int b = 0; b < len; b++) new_q[i].push_back({b == len - 1, 8'($urandom)});
            end
         end
         model_rr();
         at_edge();
         for (int i = 0; i < NREQ; i++) begin
            src_q[i] = new_q[i];
            new_q[i].delete();
         end
         wait_drain("rand");
      end

      check("sb_empty_end", exp_q.size(), 0);
`ifdef TX_ARB_STATS_EN
      check("st_byte_count", tx_byte_count, 16'(n_trans - n_trans_rst));
      check("st_pkt_count", pkt_count, 16'(n_pkts));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
